vga_capture: RTL
================

# vga_capture

Receive-side counterpart to the VGA framebuffer driver. Samples the VGA port signals (pixel clock, syncs, blank, RGB) in the system clock domain and recovers the pixel stream as (x, y, color) write events. Verifies horizontal and vertical timing and reports lock and sync errors. Used for loopback verification of the display path and as the front end of a frame-capture path into a second framebuffer.

## Interface

Parameters:

- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel strobes between consecutive hsync falling edges
- V_ACTIVE, 480, active lines per frame

Ports:

- clk  in  1  system clock; vga_clk toggles at most once per clk
- rst  in  1  reset
- vga_clk  in  1  pixel clock from the VGA port
- vga_hs  in  1  hsync, active-low
- vga_vs  in  1  vsync, active-low
- vga_blank_n  in  1  high during active video
- vga_r, vga_g, vga_b  in  8 each  pixel colour
- x  out  10  column of the current pixel event
- y  out  9  row of the current pixel event
- pixel_color  out  1  1 iff RGB == 24'hFFFFFF
- pixel_valid  out  1  one-cycle pixel write strobe
- color_error  out  1  pulses with pixel_valid when RGB is neither 24'h000000 nor 24'hFFFFFF
- frame_done  out  1  one-cycle pulse when a complete, clean frame ends
- locked  out  1  high after the first clean frame
- sync_error  out  1  one-cycle pulse on a timing violation
- frame_crc  out  16  CRC of the last clean frame

Reset: rst is synchronous and active-high; the clock is clk.

## Operation

- **Input capture.** All VGA inputs are registered twice: s1, then s2.
  - A pixel strobe is the clk cycle where s1.vga_clk=1 and s2.vga_clk=0.
  - Syncs, blank and RGB are taken from s1 on the strobe.
  - An hs fall or vs fall is a strobe where the sync is 0 in s1 and was 1 at the previous strobe.
- **State SEARCH.** Ignores all pixels. On vs fall, go to ARMED.
- **State ARMED.**
  - Clears the pixel count (pcnt), line count (lcnt) and hsync period count (hcnt).
  - The first hs fall only starts hcnt.
  - The first strobe with blank_n=1 goes to ACTIVE with x=0, y=0.
- **State ACTIVE.**
  - Each strobe with blank_n=1 emits pixel_valid with the current x, y and colour, then increments x.
  - A blank_n 1→0 transition checks x == H_ACTIVE, resets x to 0 and increments y/lcnt.
  - Each hs fall checks hcnt == H_TOTAL, then clears hcnt.
  - A vs fall checks lcnt == V_ACTIVE and blank_n == 0.
    - Pass: pulse frame_done, set locked, latch frame_crc, re-enter ARMED.
- **Any failed check.**
  - Pulse sync_error and clear locked.
  - Go to SEARCH; no frame_done for that frame.
  - The vs fall that caused the error does not re-arm the block.
- **Wrap and overflow.**
  - x saturates at 1023, so an over-long line is flagged at blank fall.
  - y saturates at 511.
  - hcnt saturates at 2047.
- **Simultaneous events.**
  - If blank fall and hs fall occur on the same strobe, both checks apply.
  - If an error and frame_done would occur on the same strobe, the error wins.
- **color_error** never affects lock.

## Timing

- Reset value of every output is 0, including frame_crc = 16'h0000; state resets to SEARCH.
- Latency: all outputs are registered. pixel_valid, frame_done and sync_error assert exactly 3 clk edges after the clk edge at which vga_clk is first sampled high.
- pixel_valid, frame_done, sync_error and color_error are single-cycle pulses. Their minimum spacing is 2 clk, one vga_clk period.
- x, y and pixel_color are valid only while pixel_valid=1; they hold their values otherwise.
- rst mid-frame: all outputs are 0 on the cycle after rst is sampled. Relock requires a vs fall, then one full clean frame.
- Nominal input is 800×524 strobes per frame, giving 838,400 clk per frame_done.

## Configuration

- **VGA_CAPTURE_CRC_EN defined:**
  - A running CRC-16-CCITT (poly 0x1021, init 16'hFFFF, MSB-first, 1 bit per pixel) is updated with pixel_color on each pixel_valid.
  - The CRC is re-initialised on entry to ARMED.
  - The final value is copied to frame_crc in the same cycle frame_done pulses.
- **Not defined:** the CRC logic is absent and frame_crc is tied to 16'h0000.

## Test plan

1. **Clean black frames.** Drive the framebuffer's port output → locked rises with the first frame_done. There are exactly 307,200 pixel_valid per frame, all with pixel_color=0, and frame_done every 838,400 clk.
2. **Single white pixel.** Write a white pixel at (639,479) → one pixel_valid with x=639, y=479, pixel_color=1; all other pixels are 0; no sync_error.
3. **Short line.** Drop blank_n after 639 pixels on line 100 → sync_error pulses, locked falls, no frame_done. Relock occurs after the next complete frame.
4. **Non-binary colour.** Force RGB=24'h808080 on one active pixel → color_error with that pixel_valid, pixel_color=0, locked stays 1.
5. **Reset mid-frame.** Assert rst at line 200 → outputs are 0 next cycle. The first frame_done comes only after a full frame following the next vs fall.
6. **CRC (macro defined).** Capture an all-black frame and a frame with one white pixel at (0,0) → frame_crc matches the golden CRC model for each. With the macro undefined, frame_crc=16'h0000.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: samples the VGA port in the clk domain, recovers (x, y, colour) pixel events and checks frame timing.
// Define VGA_CAPTURE_CRC_EN to build the per-frame CRC-16-CCITT; otherwise frame_crc is tied to zero.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_clk,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        pixel_color,
    output logic        pixel_valid,
    output logic        color_error,
    output logic        frame_done,
    output logic        locked,
    output logic        sync_error,
    output logic [15:0] frame_crc
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [9:0]  X_END = 10'(H_ACTIVE);
    localparam logic [10:0] H_PER = 11'(H_TOTAL);
    localparam logic [8:0]  Y_END = 9'(V_ACTIVE);

    // s1 holds {vga_clk, hs, vs, blank_n, rgb}; s2 only needs the pixel clock for edge detection
    logic [27:0] s1_q, s1_d;
    logic        s2_clk_q, s2_clk_d;
    logic        p1_stb_q, p1_stb_d;
    logic        p2_stb_q, p2_stb_d;
    logic [26:0] p1_data_q, p1_data_d;
    logic [26:0] p2_data_q, p2_data_d;

    logic [1:0]  state_q, state_d;
    logic        prev_hs_q, prev_hs_d;
    logic        prev_vs_q, prev_vs_d;
    logic        prev_blank_q, prev_blank_d;
    logic [9:0]  x_cnt_q, x_cnt_d;
    logic [8:0]  y_cnt_q, y_cnt_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic        hrun_q, hrun_d;

    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        color_q, color_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        color_error_q, color_error_d;
    logic        frame_done_q, frame_done_d;
    logic        locked_q, locked_d;
    logic        sync_error_q, sync_error_d;

    logic        st_hs, st_vs, st_blank;
    logic [23:0] st_rgb;
    logic        hs_fall, vs_fall, blank_fall, pix_ev;
    logic        is_white, is_black;
    logic [9:0]  x_sat;
    logic [8:0]  y_sat;
    logic [10:0] hcnt_sat;
    logic        emit, chk_err, chk_pass, enter_armed;

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_crc_q, frame_crc_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // Two-stage delay after strobe detection keeps every output exactly three edges behind the sampled pixel clock
    always_comb begin
        s1_d      = {vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
        s2_clk_d  = s1_q[27];
        p1_stb_d  = s1_q[27] & ~s2_clk_q;
        p1_data_d = s1_q[26:0];
        p2_stb_d  = p1_stb_q;
        p2_data_d = p1_data_q;
    end

    always_comb begin
        st_hs      = p2_data_q[26];
        st_vs      = p2_data_q[25];
        st_blank   = p2_data_q[24];
        st_rgb     = p2_data_q[23:0];
        hs_fall    = p2_stb_q & ~st_hs & prev_hs_q;
        vs_fall    = p2_stb_q & ~st_vs & prev_vs_q;
        blank_fall = p2_stb_q & ~st_blank & prev_blank_q;
        pix_ev     = p2_stb_q & st_blank;
        is_white   = (st_rgb == 24'hFFFFFF);
        is_black   = (st_rgb == 24'h000000);
        x_sat      = (x_cnt_q == 10'h3FF) ? x_cnt_q : x_cnt_q + 10'd1;
        y_sat      = (y_cnt_q == 9'h1FF) ? y_cnt_q : y_cnt_q + 9'd1;
        hcnt_sat   = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
    end

    always_comb begin
        state_d       = state_q;
        prev_hs_d     = prev_hs_q;
        prev_vs_d     = prev_vs_q;
        prev_blank_d  = prev_blank_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        hcnt_d        = hcnt_q;
        hrun_d        = hrun_q;
        x_d           = x_q;
        y_d           = y_q;
        color_d       = color_q;
        locked_d      = locked_q;
        pixel_valid_d = 1'b0;
        color_error_d = 1'b0;
        frame_done_d  = 1'b0;
        sync_error_d  = 1'b0;
        emit          = 1'b0;
        chk_err       = 1'b0;
        chk_pass      = 1'b0;
        enter_armed   = 1'b0;
`ifdef VGA_CAPTURE_CRC_EN
        crc_d         = crc_q;
        frame_crc_d   = frame_crc_q;
`endif

        if (p2_stb_q) begin
            prev_hs_d    = st_hs;
            prev_vs_d    = st_vs;
            prev_blank_d = st_blank;
        end

        case (state_q)
            ST_SEARCH: begin
                if (vs_fall) enter_armed = 1'b1;
            end
            ST_ARMED: begin
                if (hs_fall) begin
                    hcnt_d = 11'd1;
                    hrun_d = 1'b1;
                end else if (p2_stb_q && hrun_q) begin
                    hcnt_d = hcnt_sat;
                end
                if (vs_fall) begin
                    enter_armed = 1'b1;
                end else if (pix_ev) begin
                    emit    = 1'b1;
                    x_cnt_d = 10'd1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (p2_stb_q && hrun_q) hcnt_d = hcnt_sat;
                if (pix_ev) begin
                    emit    = 1'b1;
                    x_cnt_d = x_sat;
                end
                if (blank_fall) begin
                    if (x_cnt_q != X_END) chk_err = 1'b1;
                    x_cnt_d = 10'd0;
                    y_cnt_d = y_sat;
                end
                // hcnt counts the falling strobe itself, so a nominal line reads exactly H_TOTAL at the next fall
                if (hs_fall) begin
                    if (hrun_q && (hcnt_q != H_PER)) chk_err = 1'b1;
                    hcnt_d = 11'd1;
                    hrun_d = 1'b1;
                end
                if (vs_fall) begin
                    if ((y_cnt_q != Y_END) || st_blank) chk_err  = 1'b1;
                    else                                chk_pass = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        if (emit) begin
            pixel_valid_d = 1'b1;
            x_d           = x_cnt_q;
            y_d           = y_cnt_q;
            color_d       = is_white;
            color_error_d = ~is_white & ~is_black;
`ifdef VGA_CAPTURE_CRC_EN
            crc_d         = crc_step(crc_q, is_white);
`endif
        end

        // An error on the same strobe as a passing vsync check suppresses frame_done and does not re-arm
        if (chk_err) begin
            sync_error_d = 1'b1;
            locked_d     = 1'b0;
            state_d      = ST_SEARCH;
        end else if (chk_pass) begin
            frame_done_d = 1'b1;
            locked_d     = 1'b1;
            enter_armed  = 1'b1;
`ifdef VGA_CAPTURE_CRC_EN
            frame_crc_d  = crc_q;
`endif
        end

        if (enter_armed) begin
            state_d = ST_ARMED;
            x_cnt_d = 10'd0;
            y_cnt_d = 9'd0;
            hcnt_d  = 11'd0;
            hrun_d  = 1'b0;
`ifdef VGA_CAPTURE_CRC_EN
            crc_d   = 16'hFFFF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= '0;
            s2_clk_q      <= 1'b0;
            p1_stb_q      <= 1'b0;
            p1_data_q     <= '0;
            p2_stb_q      <= 1'b0;
            p2_data_q     <= '0;
            state_q       <= ST_SEARCH;
            prev_hs_q     <= 1'b0;
            prev_vs_q     <= 1'b0;
            prev_blank_q  <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            hcnt_q        <= '0;
            hrun_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            color_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            color_error_q <= 1'b0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_clk_q      <= s2_clk_d;
            p1_stb_q      <= p1_stb_d;
            p1_data_q     <= p1_data_d;
            p2_stb_q      <= p2_stb_d;
            p2_data_q     <= p2_data_d;
            state_q       <= state_d;
            prev_hs_q     <= prev_hs_d;
            prev_vs_q     <= prev_vs_d;
            prev_blank_q  <= prev_blank_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            hcnt_q        <= hcnt_d;
            hrun_q        <= hrun_d;
            x_q           <= x_d;
            y_q           <= y_d;
            color_q       <= color_d;
            pixel_valid_q <= pixel_valid_d;
            color_error_q <= color_error_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            sync_error_q  <= sync_error_d;
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0000;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_color = color_q;
    assign pixel_valid = pixel_valid_q;
    assign color_error = color_error_q;
    assign frame_done  = frame_done_q;
    assign locked      = locked_q;
    assign sync_error  = sync_error_q;

endmodule
